// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and sync-window helpers for the VGA raster generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync pulse occupies [visible+fp, visible+fp+sync-1] on each axis.
    function automatic int sync_start(input int visible, input int fp);
        return visible + fp;
    endfunction

    function automatic int sync_end(input int visible, input int fp, input int sync);
        return visible + fp + sync - 1;
    endfunction

    localparam int H_SYNC_START = sync_start(DEF_H_VISIBLE, DEF_H_FP);
    localparam int H_SYNC_END   = sync_end(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC);
    localparam int V_SYNC_START = sync_start(DEF_V_VISIBLE, DEF_V_FP);
    localparam int V_SYNC_END   = sync_end(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered visible/sync decodes
// computed from the next count so they stay in phase with the count output.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FP      = DEF_H_FP,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BP      = DEF_H_BP
) (
    input  logic   clk_i,
    input  logic   srst_i,
    input  logic   en_i,
    output coord_t count_o,
    output logic   wrap_o,
    output logic   visible_o,
    output logic   sync_n_o
);

    localparam int     TOTAL      = VISIBLE + FP + SYNC + BP;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t VIS_END    = coord_t'(VISIBLE);
    localparam coord_t SYNC_FIRST = coord_t'(sync_start(VISIBLE, FP));
    localparam coord_t SYNC_LAST  = coord_t'(sync_end(VISIBLE, FP, SYNC));

    coord_t count_q, count_d;
    logic   visible_q, visible_d;
    logic   sync_n_q, sync_n_d;

    assign wrap_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
        end
        visible_d = (count_d < VIS_END);
        sync_n_d  = !((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST));
    end

    // Reset parks the counter on its last position so the first enable wraps to 0.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count_q   <= LAST;
            visible_q <= 1'b0;
            sync_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            visible_q <= visible_d;
            sync_n_q  <= sync_n_d;
        end
    end

    assign count_o   = count_q;
    assign visible_o = visible_q;
    assign sync_n_o  = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-enable divider, H/V counters, DAC pin drive.
// Define VGA_RGB_REG_EN to register colour and delay sync/blank pins by one pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       pix_en,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             frame_start_q;
    logic             h_wrap, v_wrap;
    logic             h_visible, v_visible;
    logic             h_sync_n, v_sync_n;

    assign pix_en = (div_q == DIV_LAST);
    assign div_d  = pix_en ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            frame_start_q <= v_wrap;
        end
    end

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h (
        .clk_i     (Clk),
        .srst_i    (Reset),
        .en_i      (pix_en),
        .count_o   (DrawX),
        .wrap_o    (h_wrap),
        .visible_o (h_visible),
        .sync_n_o  (h_sync_n)
    );

    // Vertical axis steps only on the pixel that ends a line.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v (
        .clk_i     (Clk),
        .srst_i    (Reset),
        .en_i      (h_wrap),
        .count_o   (DrawY),
        .wrap_o    (v_wrap),
        .visible_o (v_visible),
        .sync_n_o  (v_sync_n)
    );

    assign blank       = h_visible && v_visible;
    assign frame_start = frame_start_q;

`ifdef VGA_RGB_REG_EN
    logic [7:0] r_q, g_q, b_q;
    logic       hs_q, vs_q, blank_n_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_en) begin
            r_q       <= blank ? Red_in   : '0;
            g_q       <= blank ? Green_in : '0;
            b_q       <= blank ? Blue_in  : '0;
            hs_q      <= h_sync_n;
            vs_q      <= v_sync_n;
            blank_n_q <= blank;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
`else
    assign VGA_R       = blank ? Red_in   : '0;
    assign VGA_G       = blank ? Green_in : '0;
    assign VGA_B       = blank ? Blue_in  : '0;
    assign VGA_HS      = h_sync_n;
    assign VGA_VS      = v_sync_n;
    assign VGA_BLANK_N = blank;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a short-frame instance (full horizontal timing, 9-line frame) and a
// default-geometry instance share stimulus; expectations come from pixel-index arithmetic.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int DIV   = 2;
    localparam int HT    = 800;
    localparam int HVIS  = 640;
    localparam int HS0   = 656;
    localparam int HS1   = 751;
    localparam int VT    = 9;
    localparam int VVIS  = 4;
    localparam int VS0   = 5;
    localparam int VS1   = 6;
    localparam int VTD   = 525;
    localparam int VVISD = 480;
    localparam int VS0D  = 490;
    localparam int VS1D  = 491;
    localparam int FRAME  = HT * VT;
    localparam int FRAMED = HT * VTD;

    typedef struct {
        int x; int y; bit vis; bit hs; bit vs;
    } pos_t;

    typedef struct {
        int n;
        int x; int y; bit blank; bit hs; bit vs; bit bn; logic [23:0] rgb;
        int dx; int dy; bit dblank; bit dhs; bit dvs; bit dbn; logic [23:0] drgb;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Red_in, Green_in, Blue_in;

    logic [9:0] DrawX, DrawY;
    logic       blank, pix_en, frame_start, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    logic [9:0] d_DrawX, d_DrawY;
    logic       d_blank, d_pix_en, d_frame_start, d_VGA_HS, d_VGA_VS, d_VGA_BLANK_N;
    logic [7:0] d_VGA_R, d_VGA_G, d_VGA_B;

    vga_timing_gen #(
        .V_VISIBLE (VVIS),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .pix_en(pix_en), .frame_start(frame_start),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    vga_timing_gen dut_d (
        .Clk(Clk), .Reset(Reset), .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
        .DrawX(d_DrawX), .DrawY(d_DrawY), .blank(d_blank), .pix_en(d_pix_en),
        .frame_start(d_frame_start), .VGA_HS(d_VGA_HS), .VGA_VS(d_VGA_VS),
        .VGA_BLANK_N(d_VGA_BLANK_N), .VGA_R(d_VGA_R), .VGA_G(d_VGA_G), .VGA_B(d_VGA_B)
    );

    always #5 Clk = ~Clk;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pushes = 0;
    int          pops   = 0;
    int          pix_n  = -1;
    bit          mon_en = 1'b0;
    bit          fs_en  = 1'b0;
    bit          exp_fs = 1'b0;
    bit          exp_fs_d = 1'b0;
    logic [23:0] cur_col = '0;
    logic [23:0] prev_col = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel n counts from the first pixel after reset release (n = -1 is the parked state).
    function automatic pos_t locate(input int n, input int vt, input int vvis,
                                    input int vs0, input int vs1);
        pos_t p;
        int   m;
        m     = n + 2 * HT * vt;
        p.x   = m % HT;
        p.y   = (m / HT) % vt;
        p.vis = (p.x < HVIS) && (p.y < vvis);
        p.hs  = !((p.x >= HS0) && (p.x <= HS1));
        p.vs  = !((p.y >= vs0) && (p.y <= vs1));
        return p;
    endfunction

    function automatic exp_t build(input int n, input logic [23:0] cur, input logic [23:0] prev);
        exp_t        e;
        pos_t        c, cd, pp, pd;
        logic [23:0] col;
        c  = locate(n, VT, VVIS, VS0, VS1);
        cd = locate(n, VTD, VVISD, VS0D, VS1D);
`ifdef VGA_RGB_REG_EN
        pp  = locate(n - 1, VT, VVIS, VS0, VS1);
        pd  = locate(n - 1, VTD, VVISD, VS0D, VS1D);
        col = prev;
`else
        pp  = c;
        pd  = cd;
        col = cur;
`endif
        e.n = n;
        e.x = c.x;  e.y = c.y;  e.blank = c.vis;
        e.hs = pp.hs; e.vs = pp.vs; e.bn = pp.vis; e.rgb = pp.vis ? col : 24'h0;
        e.dx = cd.x; e.dy = cd.y; e.dblank = cd.vis;
        e.dhs = pd.hs; e.dvs = pd.vs; e.dbn = pd.vis; e.drgb = pd.vis ? col : 24'h0;
        return e;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
        exp_fs   = 1'b0;
        exp_fs_d = 1'b0;
    endtask

    task automatic start_pixel();
        pos_t p;
        p        = locate(pix_n, VT, VVIS, VS0, VS1);
        prev_col = cur_col;
        if ((p.x == 10 && p.y == 3) || p.x == 700)
            cur_col = {8'hFF, 16'($urandom())};
        else
            cur_col = 24'($urandom());
        {Red_in, Green_in, Blue_in} = cur_col;
        exp_q.push_back(build(pix_n, cur_col, prev_col));
        pushes++;
        exp_fs   = (pix_n % FRAME == 0);
        exp_fs_d = (pix_n % FRAMED == 0);
    endtask

    task automatic run(input int npix);
        $display("run %0d pixels from pixel %0d", npix, pix_n + 1);
        for (int k = 0; k < npix; k++) begin
            repeat (DIV) tick();
            pix_n++;
            start_pixel();
        end
    endtask

    task automatic do_reset(input int hold);
        $display("reset hold=%0d cycles at pixel %0d", hold, pix_n + 1);
        Reset = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            fs_en = 1'b1;
            check("rst_coord", {DrawX, DrawY}, {10'(HT - 1), 10'(VT - 1)});
            check("rst_pins", {blank, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start}, 5'b01100);
            check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
            check("rst_dflt", {d_DrawX, d_DrawY, d_blank, d_VGA_HS, d_VGA_VS, d_VGA_BLANK_N},
                  {10'd799, 10'd524, 4'b0110});
        end
        Reset = 1'b0;
        pix_n = -1;
        start_pixel();
    endtask

    always @(negedge Clk) begin
        if (mon_en && !Reset && pix_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                pops++;
                check("coord", {DrawX, DrawY}, {10'(e.x), 10'(e.y)});
                check("decode", {blank, VGA_HS, VGA_VS, VGA_BLANK_N}, {e.blank, e.hs, e.vs, e.bn});
                check("rgb", {VGA_R, VGA_G, VGA_B}, e.rgb);
                check("dflt", {d_pix_en, d_DrawX, d_DrawY, d_blank, d_VGA_HS, d_VGA_VS,
                               d_VGA_BLANK_N, d_VGA_R, d_VGA_G, d_VGA_B},
                      {1'b1, 10'(e.dx), 10'(e.dy), e.dblank, e.dhs, e.dvs, e.dbn, e.drgb});
            end
        end
    end

    always @(negedge Clk) begin
        if (fs_en) begin
            check("frame_start", {63'd0, frame_start}, {63'd0, exp_fs});
            check("frame_start_dflt", {63'd0, d_frame_start}, {63'd0, exp_fs_d});
        end
    end

    initial begin
        Reset    = 1'b1;
        Red_in   = '0;
        Green_in = '0;
        Blue_in  = '0;
        mon_en   = 1'b1;
        do_reset(3);
        run(2 * FRAME + 20);
        // Stop just before (300,2) of the third frame, then reset as that pixel begins.
        run(2 * FRAME + 2 * HT + 299 - pix_n);
        repeat (DIV) tick();
        do_reset(1 + int'($urandom_range(2)));
        run(2 * HT + 60);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge Clk);
        mon_en = 1'b0;
        fs_en  = 1'b0;
        check("drain", 64'(exp_q.size()), 64'd0);
        check("pops", 64'(pops), 64'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
